key_schedule_seq: RTL and testbench

Sequential AES-128 key expansion for the iterative encryption datapath. Loads a 128-bit cipher key and presents round keys 0..10 one at a time, advancing on a consumer handshake. It sits directly upstream of the round logic: the initial AddRoundKey, the nine middle rounds and the last round take their key array from this block. S-box lookups for SubWord are internal to this block.

---
 rtl/key_schedule_seq.sv | 122 ++++++++++++
 tb/tb_key_schedule_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_seq.sv
// Sequential AES-128 key expansion: loads a cipher key and presents round keys 0..10
// one per consumer handshake, expanding the stored key in place each step.
module key_schedule_seq (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [127:0] i_key,
  input  logic         i_next,
  output logic [127:0] o_roundKey,
  output logic [3:0]   o_round,
  output logic         o_keyValid,
  output logic         o_busy,
  output logic         o_done
);

  localparam int unsigned KeyW   = 128;
  localparam int unsigned RoundW = 4;
  localparam logic [RoundW-1:0] LastRound = RoundW'(10);

  // Forward S-box, byte 0x00 in the most significant position
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e              state_q;
  logic [KeyW-1:0]     key_q;
  logic [KeyW-1:0]     key_d;
  logic [RoundW-1:0]   round_q;
  logic                valid_q;
  logic                done_q;
  logic [7:0]          rcon_c;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  // Rcon for the round being produced (round_q + 1)
  always_comb begin
    rcon_c = 8'h00;
    case (round_q)
      4'd0:    rcon_c = 8'h01;
      4'd1:    rcon_c = 8'h02;
      4'd2:    rcon_c = 8'h04;
      4'd3:    rcon_c = 8'h08;
      4'd4:    rcon_c = 8'h10;
      4'd5:    rcon_c = 8'h20;
      4'd6:    rcon_c = 8'h40;
      4'd7:    rcon_c = 8'h80;
      4'd8:    rcon_c = 8'h1b;
      4'd9:    rcon_c = 8'h36;
      default: rcon_c = 8'h00;
    endcase
  end

  // One full key expansion step in a single cycle
  always_comb begin
    logic [31:0] t, w0, w1, w2, w3;
    t     = sub_word({key_q[23:0], key_q[31:24]}) ^ {rcon_c, 24'h000000};
    w0    = key_q[127:96] ^ t;
    w1    = key_q[95:64]  ^ w0;
    w2    = key_q[63:32]  ^ w1;
    w3    = key_q[31:0]   ^ w2;
    key_d = {w0, w1, w2, w3};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            key_q   <= i_key;
            round_q <= '0;
            valid_q <= 1'b1;
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (i_next) begin
            if (round_q == LastRound) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              key_q   <= key_d;
              round_q <= round_q + RoundW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_roundKey = key_q;
  assign o_round    = round_q;
  assign o_keyValid = valid_q;
  assign o_busy     = valid_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Self-checking bench for key_schedule_seq: scoreboard against an independently
// derived key-expansion model plus FIPS-197 reference round keys.
module tb_key_schedule_seq;

  logic         clk, rst, start, next;
  logic [127:0] key;
  logic [127:0] o_roundKey;
  logic [3:0]   o_round;
  logic         o_keyValid, o_busy, o_done;

  key_schedule_seq dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_key(key), .i_next(next),
    .o_roundKey(o_roundKey), .o_round(o_round), .o_keyValid(o_keyValid),
    .o_busy(o_busy), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C1_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct packed { logic [3:0] rnd; logic [127:0] key; } exp_t;
  typedef struct { logic [127:0] key; int rnd; logic [127:0] exp; } vec_t;

  int errors = 0;
  int checks = 0;
  logic [7:0]   sb [256];
  exp_t         exp_q [$];
  bit           m_active, m_done;
  int           m_round;
  logic [127:0] m_key;
  bit           prev_valid;
  logic [3:0]   cur_round;
  logic [127:0] cur_key;
  logic [127:0] seen [11];
  int           nv;
  bit           done_seen;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from GF(2^8) inverse and affine transform
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, bx;
      bx = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(bx, 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] m_rcon(input int r);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = xtime(rc);
    return rc;
  endfunction

  function automatic logic [127:0] m_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sb[k[23:16]], sb[k[15:8]], sb[k[7:0]], sb[k[31:24]]} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  task automatic model_reset();
    m_active = 0; m_done = 0; m_round = 0; m_key = '0;
    exp_q.delete();
    prev_valid = 0;
  endtask

  // One clock: drive at negedge, update model and scoreboard, compare after posedge
  task automatic cycle(input bit st, input logic [127:0] k, input bit nx);
    exp_t e;
    @(negedge clk);
    start = st; key = k; next = nx;
    @(posedge clk);
    #1;
    m_done = 0;
    if (!m_active) begin
      if (st) begin
        m_active = 1; m_round = 0; m_key = k;
        exp_q.push_back('{rnd: 4'd0, key: k});
      end
    end else if (nx) begin
      if (m_round == 10) begin
        m_active = 0; m_done = 1;
      end else begin
        m_key = m_expand(m_key, m_rcon(m_round + 1));
        m_round++;
        exp_q.push_back('{rnd: 4'(m_round), key: m_key});
      end
    end
    chk("valid", 128'(o_keyValid), 128'(m_active));
    chk("busy", 128'(o_busy), 128'(m_active));
    chk("done", 128'(o_done), 128'(m_done));
    if (o_keyValid && (!prev_valid || o_round != cur_round)) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: got round %0d with no expected entry", o_round);
      end else begin
        e = exp_q.pop_front();
        chk("sb_round", 128'(o_round), 128'(e.rnd));
        chk("sb_key", o_roundKey, e.key);
      end
      if (o_round <= 4'd10) seen[o_round] = o_roundKey;
      cur_round = o_round;
      cur_key = o_roundKey;
    end else if (o_keyValid) begin
      chk("stable_round", 128'(o_round), 128'(cur_round));
      chk("stable_key", o_roundKey, cur_key);
    end
    chk("sb_pending", 128'(exp_q.size()), 128'(0));
    prev_valid = o_keyValid;
  endtask

  // Start with i_next also high, then hold i_next until done
  task automatic run_full(input logic [127:0] k);
    for (int i = 0; i < 11; i++) seen[i] = 'x;
    cycle(1'b1, k, 1'b1);
    nv = o_keyValid ? 1 : 0;
    done_seen = 0;
    for (int i = 0; i < 20 && !done_seen; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (o_keyValid) nv++;
      if (o_done) done_seen = 1;
    end
    chk("done_reached", 128'(done_seen), 128'(1));
    chk("valid_cycles", 128'(nv), 128'(11));
  endtask

  vec_t vecs [5];

  initial begin
    rst = 1'b1; start = 0; next = 0; key = '0;
    build_sbox();
    model_reset();
    #2;
    chk("rst_key", o_roundKey, '0);
    chk("rst_round", 128'(o_round), 128'(0));
    chk("rst_valid", 128'(o_keyValid), 128'(0));
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_done", 128'(o_done), 128'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);

    vecs[0] = '{KEY_A1, 0,  KEY_A1};
    vecs[1] = '{KEY_A1, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{KEY_A1, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3] = '{KEY_A1, 10, A1_R10};
    vecs[4] = '{KEY_C1, 10, C1_R10};
    for (int v = 0; v < 5; v++) begin
      run_full(vecs[v].key);
      chk($sformatf("vec%0d_r%0d", v, vecs[v].rnd), seen[vecs[v].rnd], vecs[v].exp);
    end

    // Back-to-back: start in the o_done cycle
    run_full(KEY_A1);
    cycle(1'b1, KEY_C1, 1'b0);
    chk("b2b_valid", 128'(o_keyValid), 128'(1));
    chk("b2b_round", 128'(o_round), 128'(0));
    chk("b2b_key", o_roundKey, KEY_C1);
    done_seen = 0;
    for (int i = 0; i < 20 && !done_seen; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (o_done) done_seen = 1;
    end
    chk("b2b_r10", seen[10], C1_R10);

    // Random stalls with an ignored start at round 5
    cycle(1'b1, KEY_A1, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 400 && !done_seen; i++) begin
      if (m_active && m_round == 5 && i % 7 == 0) cycle(1'b1, KEY_C1, 1'b0);
      else cycle(1'b0, '0, $urandom_range(0, 9) < 3);
      if (o_done) done_seen = 1;
    end
    chk("stall_done", 128'(done_seen), 128'(1));
    chk("stall_r10", seen[10], A1_R10);

    // i_next in IDLE does nothing
    for (int i = 0; i < 3; i++) cycle(1'b0, KEY_C1, 1'b1);
    chk("idle_next_valid", 128'(o_keyValid), 128'(0));

    // Asynchronous reset at round 4, then a fresh schedule
    cycle(1'b1, KEY_A1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
    chk("pre_rst_round", 128'(o_round), 128'(4));
    #3 rst = 1'b1;
    #1;
    chk("arst_key", o_roundKey, '0);
    chk("arst_round", 128'(o_round), 128'(0));
    chk("arst_valid", 128'(o_keyValid), 128'(0));
    chk("arst_busy", 128'(o_busy), 128'(0));
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("arst_no_done", 128'(o_done), 128'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, '0, 1'b0);
    chk("post_rst_idle", 128'(o_keyValid), 128'(0));
    run_full(KEY_C1);
    chk("post_rst_r10", seen[10], C1_R10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
